// File: rtl/sram_port_arbiter_if.sv
// Bundles the recorder write port, the player read port and the SRAM pin bus.
// Latency: none, signals only.
// Backpressure: req is held by the requester until its ack pulse; there is no other stall path.
// Ports: slave  = arbiter side (samples requests and SRAM read data, drives acks and SRAM pins)
//        master = environment side (recorder, player and the SRAM device)
interface sram_port_arbiter_if;
    // recorder write port
    logic        i_wr_req;
    logic [19:0] i_wr_addr;
    logic [15:0] i_wr_data;
    logic [1:0]  i_wr_be;
    logic        o_wr_ack;
    // player read port
    logic        i_rd_req;
    logic [19:0] i_rd_addr;
    logic [15:0] o_rd_data;
    logic        o_rd_ack;
    // SRAM pins; the tristate buffer lives outside the arbiter
    logic        o_sram_ce_n;
    logic        o_sram_we_n;
    logic        o_sram_oe_n;
    logic        o_sram_lb_n;
    logic        o_sram_ub_n;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_dq;
    logic        o_sram_dq_oe;
    logic [15:0] i_sram_dq;
    // status
    logic        o_busy;

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_wr_be, i_rd_req, i_rd_addr, i_sram_dq,
        output o_wr_ack, o_rd_data, o_rd_ack,
        output o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n,
        output o_sram_addr, o_sram_dq, o_sram_dq_oe, o_busy
    );

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_wr_be, i_rd_req, i_rd_addr, i_sram_dq,
        input  o_wr_ack, o_rd_data, o_rd_ack,
        input  o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n,
        input  o_sram_addr, o_sram_dq, o_sram_dq_oe, o_busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between a write port and a read port.
// Latency: grant edge to ack cycle is WR_PULSE_CYC+2 (write) / RD_WAIT_CYC+2 (read); one IDLE cycle between accesses.
// Backpressure: requests are sampled only in IDLE; a requester holds req until ack. All outputs are registered.
// Ports: i_bclk clock, i_rst async active-low reset, bus = sram_port_arbiter_if.slave (ports + SRAM pins).
module sram_port_arbiter #(
    parameter int WR_PULSE_CYC = 1,   // cycles WE_N is held low, 1..15
    parameter int RD_WAIT_CYC  = 1    // cycles address/OE_N are valid before the sample cycle, 1..15
) (
    input  logic                 i_bclk,
    input  logic                 i_rst,
    sram_port_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_ADDR, RD_SAMPLE, RD_DONE
    } state_t;

    // counters run down to zero, so a phase of N cycles loads N-1
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_PULSE_CYC - 1);
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_WAIT_CYC - 1);

    state_t      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic        last_wr_q, last_wr_d;   // 1 = write port was granted last
    logic [19:0] addr_q,    addr_d;
    logic [15:0] wdata_q,   wdata_d;
    logic [1:0]  be_q,      be_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        ce_n_q,    ce_n_d;
    logic        we_n_q,    we_n_d;
    logic        oe_n_q,    oe_n_d;
    logic        lb_n_q,    lb_n_d;
    logic        ub_n_q,    ub_n_d;
    logic        dq_oe_q,   dq_oe_d;
    logic        wr_ack_q,  wr_ack_d;
    logic        rd_ack_q,  rd_ack_d;
    logic        busy_q,    busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_data_d = rd_data_q;

        unique case (state_q)
            IDLE: begin
                // write wins when alone, or on a tie when the read port had the last grant
                if (bus.i_wr_req && (!bus.i_rd_req || !last_wr_q)) begin
                    state_d   = WR_SETUP;
                    last_wr_d = 1'b1;
                    addr_d    = bus.i_wr_addr;
                    wdata_d   = bus.i_wr_data;
                    be_d      = bus.i_wr_be;
                end else if (bus.i_rd_req) begin
                    state_d   = RD_ADDR;
                    cnt_d     = RD_CNT_INIT;
                    last_wr_d = 1'b0;
                    addr_d    = bus.i_rd_addr;
                end
            end
            WR_SETUP: begin
                state_d = WR_STROBE;
                cnt_d   = WR_CNT_INIT;
            end
            WR_STROBE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD:   state_d = IDLE;
            RD_ADDR: begin
                if (cnt_q == 4'd0) state_d = RD_SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RD_SAMPLE: begin
                state_d   = RD_DONE;
                rd_data_d = bus.i_sram_dq;
            end
            RD_DONE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered pins line up
        // with the state they describe, without a combinational path to the pins.
        ce_n_d   = 1'b1;
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        wr_ack_d = 1'b0;
        rd_ack_d = 1'b0;
        busy_d   = (state_d != IDLE);

        unique case (state_d)
            WR_SETUP, WR_STROBE, WR_HOLD: begin
                ce_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                lb_n_d   = ~be_d[0];
                ub_n_d   = ~be_d[1];
                we_n_d   = (state_d != WR_STROBE);
                wr_ack_d = (state_d == WR_HOLD);
            end
            RD_ADDR, RD_SAMPLE: begin
                // OE_N low only here, while dq_oe is held low, so the bus never contends
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
            RD_DONE:  rd_ack_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_bclk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_wr_q <= 1'b0;    // read counts as last grant, so the first tie goes to write
            addr_q    <= 20'd0;
            wdata_q   <= 16'd0;
            be_q      <= 2'b00;
            rd_data_q <= 16'd0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_data_q <= rd_data_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
            dq_oe_q   <= dq_oe_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_sram_ce_n  = ce_n_q;
    assign bus.o_sram_we_n  = we_n_q;
    assign bus.o_sram_oe_n  = oe_n_q;
    assign bus.o_sram_lb_n  = lb_n_q;
    assign bus.o_sram_ub_n  = ub_n_q;
    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_dq    = wdata_q;
    assign bus.o_sram_dq_oe = dq_oe_q;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_wr_ack     = wr_ack_q;
    assign bus.o_rd_ack     = rd_ack_q;
    assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: default-parameter and (3,2)-parameter instances.
// Latency: checks per-cycle pin waveforms against timing derived from the access rules.
// Backpressure: requesters hold req until ack and drop it the cycle after.
module tb_sram_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if bus ();
    sram_port_arbiter_if bus_p ();

    sram_port_arbiter u_dut (
        .i_bclk (clk),
        .i_rst  (rst_n),
        .bus    (bus)
    );

    sram_port_arbiter #(.WR_PULSE_CYC(3), .RD_WAIT_CYC(2)) u_dut_p (
        .i_bclk (clk),
        .i_rst  (rst_n),
        .bus    (bus_p)
    );

    // SRAM device model for the default instance: 256 words, aliased on addr[7:0]
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!bus.o_sram_ce_n && !bus.o_sram_we_n) begin
            if (!bus.o_sram_lb_n) mem[bus.o_sram_addr[7:0]][7:0]  <= bus.o_sram_dq[7:0];
            if (!bus.o_sram_ub_n) mem[bus.o_sram_addr[7:0]][15:8] <= bus.o_sram_dq[15:8];
        end
    end
    assign bus.i_sram_dq   = (!bus.o_sram_ce_n && !bus.o_sram_oe_n) ? mem[bus.o_sram_addr[7:0]] : 16'hDEAD;
    // second instance: device returns a fixed function of the address
    assign bus_p.i_sram_dq = bus_p.o_sram_addr[15:0] ^ 16'h5A5A;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // the data bus must never be driven while the SRAM drives it
    always @(negedge clk) begin
        if (rst_n) begin
            check("bus contention", {30'd0, (!bus.o_sram_oe_n && bus.o_sram_dq_oe),
                                            (!bus_p.o_sram_oe_n && bus_p.o_sram_dq_oe)}, 32'd0);
        end
    end

    // {ce_n, we_n, oe_n, lb_n, ub_n, dq_oe, wr_ack, rd_ack, busy}
    function automatic logic [8:0] ctrl(input bit p);
        if (!p) return {bus.o_sram_ce_n, bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_lb_n,
                        bus.o_sram_ub_n, bus.o_sram_dq_oe, bus.o_wr_ack, bus.o_rd_ack, bus.o_busy};
        return {bus_p.o_sram_ce_n, bus_p.o_sram_we_n, bus_p.o_sram_oe_n, bus_p.o_sram_lb_n,
                bus_p.o_sram_ub_n, bus_p.o_sram_dq_oe, bus_p.o_wr_ack, bus_p.o_rd_ack, bus_p.o_busy};
    endfunction

    // expected pins in cycle k after the grant edge (k = n+3 is the IDLE cycle that follows)
    function automatic logic [8:0] exp_ctrl(input bit wr, input logic [1:0] be, input int k, input int n);
        int   len;
        logic ce, we, oe, lb, ub, dqoe, wa, ra, bsy;
        len = n + 2;
        ce = 1; we = 1; oe = 1; lb = 1; ub = 1; dqoe = 0; wa = 0; ra = 0;
        bsy = (k <= len);
        if (wr && k <= len) begin
            ce = 0; dqoe = 1; lb = ~be[0]; ub = ~be[1];
            we = !(k >= 2 && k <= n + 1);
            wa = (k == len);
        end else if (!wr && k <= n + 1) begin
            ce = 0; oe = 0; lb = 0; ub = 0;
        end else if (!wr && k == len) begin
            ra = 1;
        end
        return {ce, we, oe, lb, ub, dqoe, wa, ra, bsy};
    endfunction

    task automatic drive_req(input bit p, input bit wr, input logic req, input logic [19:0] a,
                             input logic [15:0] d, input logic [1:0] be);
        if (!p) begin
            if (wr) begin bus.i_wr_req = req; bus.i_wr_addr = a; bus.i_wr_data = d; bus.i_wr_be = be; end
            else    begin bus.i_rd_req = req; bus.i_rd_addr = a; end
        end else begin
            if (wr) begin bus_p.i_wr_req = req; bus_p.i_wr_addr = a; bus_p.i_wr_data = d; bus_p.i_wr_be = be; end
            else    begin bus_p.i_rd_req = req; bus_p.i_rd_addr = a; end
        end
    endtask

    // One complete access on instance p, checked cycle by cycle.
    task automatic access(input bit p, input bit wr, input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] be, input logic [15:0] exp_rd, input string tag,
                          output int ack_cyc, output int we_low);
        int         n, len;
        bit         got;
        logic [8:0] c;
        logic [19:0] sa;
        logic [15:0] sd, rd;
        n   = p ? (wr ? 3 : 2) : 1;
        len = n + 2;
        got = 0;
        ack_cyc = 0;
        we_low  = 0;
        @(negedge clk);
        drive_req(p, wr, 1'b1, a, d, be);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            c = ctrl(p);
            if (c[0]) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s grant: got no busy within 20 cycles, expected a grant", tag);
            drive_req(p, wr, 1'b0, a, d, be);
            return;
        end
        for (int k = 1; k <= len + 1; k++) begin
            c  = ctrl(p);
            sa = p ? bus_p.o_sram_addr : bus.o_sram_addr;
            sd = p ? bus_p.o_sram_dq   : bus.o_sram_dq;
            rd = p ? bus_p.o_rd_data   : bus.o_rd_data;
            check($sformatf("%s c%0d ctrl", tag, k), {23'd0, c}, {23'd0, exp_ctrl(wr, be, k, n)});
            check($sformatf("%s c%0d addr", tag, k), {12'd0, sa}, {12'd0, a});
            if (wr && k <= len) check($sformatf("%s c%0d dq", tag, k), {16'd0, sd}, {16'd0, d});
            if (!wr && k >= len) check($sformatf("%s c%0d rd_data", tag, k), {16'd0, rd}, {16'd0, exp_rd});
            if (c[2] || c[1]) ack_cyc = k;
            if (!c[7]) we_low++;
            // inputs changing after the grant must not affect the access in flight
            if (k == 1) drive_req(p, wr, 1'b1, ~a, ~d, ~be);
            if (k == len) begin
                @(posedge clk); #1;
                drive_req(p, wr, 1'b0, ~a, ~d, ~be);
                @(negedge clk);
            end else if (k < len) begin
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        bit          p;
        bit          wr;
        logic [19:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp_rd;
        int          exp_ack;
        int          exp_we_low;
    } vec_t;

    vec_t        tbl [10];
    logic [15:0] ref_mem [256];

    initial begin
        int ack_cyc, we_low;
        bit          kinds [4];
        int          gaps  [4];
        int          ng, idle_run, acks;
        bit          prev_busy, hit;

        tbl[0] = '{0, 1, 20'h00010, 16'hA5C3, 2'b11, 16'h0000, 3, 1};
        tbl[1] = '{0, 0, 20'h00010, 16'h0000, 2'b00, 16'hA5C3, 3, 0};
        tbl[2] = '{0, 1, 20'h00010, 16'h1234, 2'b01, 16'h0000, 3, 1};
        tbl[3] = '{0, 0, 20'h00010, 16'h0000, 2'b00, 16'hA534, 3, 0};
        tbl[4] = '{0, 1, 20'h00020, 16'hFFFF, 2'b00, 16'h0000, 3, 1};
        tbl[5] = '{0, 0, 20'h00020, 16'h0000, 2'b00, 16'h0000, 3, 0};
        tbl[6] = '{0, 1, 20'h00020, 16'h7788, 2'b10, 16'h0000, 3, 1};
        tbl[7] = '{0, 0, 20'h00020, 16'h0000, 2'b00, 16'h7700, 3, 0};
        tbl[8] = '{1, 1, 20'h00030, 16'hCAFE, 2'b11, 16'h0000, 5, 3};
        tbl[9] = '{1, 0, 20'h00031, 16'h0000, 2'b00, 16'h5A6B, 4, 0};

        drive_req(0, 1, 1'b0, 20'd0, 16'd0, 2'b00);
        drive_req(0, 0, 1'b0, 20'd0, 16'd0, 2'b00);
        drive_req(1, 1, 1'b0, 20'd0, 16'd0, 2'b00);
        drive_req(1, 0, 1'b0, 20'd0, 16'd0, 2'b00);

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ctrl",    {23'd0, ctrl(0)}, {23'd0, 9'b111110000});
        check("reset ctrl p",  {23'd0, ctrl(1)}, {23'd0, 9'b111110000});
        check("reset addr",    {12'd0, bus.o_sram_addr}, 32'd0);
        check("reset dq",      {16'd0, bus.o_sram_dq},   32'd0);
        check("reset rd_data", {16'd0, bus.o_rd_data},   32'd0);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            access(tbl[i].p, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].exp_rd,
                   $sformatf("tbl%0d", i), ack_cyc, we_low);
            check($sformatf("tbl%0d ack cycle", i), ack_cyc, tbl[i].exp_ack);
            check($sformatf("tbl%0d we_n low cycles", i), we_low, tbl[i].exp_we_low);
        end
        check("byte write kept high byte", {16'd0, mem[8'h10]}, 32'h0000A534);

        // tie after reset: both requests held continuously
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive_req(0, 1, 1'b1, 20'h00040, 16'h1111, 2'b11);
        drive_req(0, 0, 1'b1, 20'h00041, 16'h0000, 2'b00);
        ng = 0; idle_run = 0; prev_busy = 0;
        for (int t = 0; t < 60 && ng < 4; t++) begin
            @(negedge clk);
            if (bus.o_busy && !prev_busy) begin
                kinds[ng] = bus.o_sram_dq_oe;
                gaps[ng]  = idle_run;
                ng++;
            end
            idle_run  = bus.o_busy ? 0 : idle_run + 1;
            prev_busy = bus.o_busy;
        end
        drive_req(0, 1, 1'b0, 20'h00040, 16'h1111, 2'b11);
        drive_req(0, 0, 1'b0, 20'h00041, 16'h0000, 2'b00);
        check("tie grant count", ng, 4);
        for (int i = 0; i < ng; i++) begin
            check($sformatf("tie grant%0d is_write", i), {31'd0, kinds[i]}, {31'd0, (i % 2 == 0)});
            if (i > 0) check($sformatf("tie gap%0d idle cycles", i), gaps[i], 1);
        end
        hit = 0;
        for (int t = 0; t < 20 && !hit; t++) begin
            @(negedge clk);
            if (!bus.o_busy) hit = 1;
        end
        check("tie drains to idle", {31'd0, hit}, 32'd1);

        // reset during WR_STROBE
        @(negedge clk);
        drive_req(0, 1, 1'b1, 20'h00050, 16'h5555, 2'b11);
        hit = 0;
        for (int t = 0; t < 20 && !hit; t++) begin
            @(negedge clk);
            if (!bus.o_sram_we_n) hit = 1;
        end
        check("reached strobe", {31'd0, hit}, 32'd1);
        rst_n = 1'b0;
        drive_req(0, 1, 1'b0, 20'h00050, 16'h5555, 2'b11);
        #1;
        check("abort ctrl", {23'd0, ctrl(0)}, {23'd0, 9'b111110000});
        @(negedge clk); rst_n = 1'b1;
        acks = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            acks += {31'd0, bus.o_wr_ack} + {31'd0, bus.o_busy};
        end
        check("no ack or busy after abort", acks, 0);

        // randomized accesses against a word-level memory model (device memory is clear after reset)
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            bit          wr;
            logic [19:0] a;
            logic [15:0] d;
            logic [1:0]  be;
            wr = 1'($urandom_range(0, 1));
            a  = {12'($urandom), 8'($urandom_range(0, 7))};
            d  = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            access(0, wr, a, d, be, ref_mem[a[7:0]], $sformatf("rnd%0d", i), ack_cyc, we_low);
            check($sformatf("rnd%0d ack cycle", i), ack_cyc, 3);
            if (wr) begin
                if (be[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
                if (be[1]) ref_mem[a[7:0]][15:8] = d[15:8];
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
